hpdmc_busif_mp: RTL and testbench

- Multi-port FML bus interface for HPDMC; parametrised successor to the single-port bus interface.
- Arbitrates 2**port_bits FML masters onto the single mgmt command port.
- Keeps up to 2**pend_bits commands in flight and routes each data_ack back to the port that issued it, in issue order.
- Sits between the FML masters and the mgmt/datapath blocks; exports the owning port index so the datapath can steer data.

---
 rtl/hpdmc_busif_mp.sv | 205 ++++++++++++++++++++
 tb/tb_hpdmc_busif_mp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_busif_mp.sv
// hpdmc_busif_mp -- multi-port FML bus interface for HPDMC.
//
// Arbitrates 2**port_bits FML masters onto the single mgmt command port, keeps
// up to 2**pend_bits accepted commands in flight, and routes each data_ack back
// to the port that issued the oldest outstanding command.
//
// Configuration macro:
//   HPDMC_BUSIF_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins)
//                              undefined -> round-robin starting after last grant
//
// Ports:
//   sys_clk       system clock, rising edge
//   sdram_rst     synchronous active-high reset
//   fml_adr       per-port byte address, port p at [p*sdram_depth +: sdram_depth]
//   fml_stb       per-port strobe, held until that port's fml_ack
//   fml_we        per-port write enable
//   fml_ack       per-port acknowledge, one-hot, start of the data phase
//   mgmt_stb      command request to mgmt
//   mgmt_we       write flag of the granted port
//   mgmt_address  granted port address in 64-bit words
//   mgmt_ack      mgmt accepted the command this cycle
//   data_ack      one pulse per accepted command, in acceptance order
//   data_port     port owning the current/next data phase (queue head)
//   pending       commands accepted but not yet data-acked

module hpdmc_busif_mp #(
  parameter int unsigned sdram_depth = 26,
  parameter int unsigned port_bits   = 1,
  parameter int unsigned pend_bits   = 2
) (
  input  logic                                    sys_clk,
  input  logic                                    sdram_rst,
  input  logic [(1<<port_bits)*sdram_depth-1:0]   fml_adr,
  input  logic [(1<<port_bits)-1:0]               fml_stb,
  input  logic [(1<<port_bits)-1:0]               fml_we,
  output logic [(1<<port_bits)-1:0]               fml_ack,
  output logic                                    mgmt_stb,
  output logic                                    mgmt_we,
  output logic [sdram_depth-4:0]                  mgmt_address,
  input  logic                                    mgmt_ack,
  input  logic                                    data_ack,
  output logic [port_bits-1:0]                    data_port,
  output logic [pend_bits:0]                      pending
);

  localparam int unsigned NPorts = 1 << port_bits;
  localparam int unsigned Depth  = 1 << pend_bits;

  localparam logic [pend_bits:0]   FullCount = (pend_bits + 1)'(Depth);
  localparam logic [pend_bits:0]   PendOne   = (pend_bits + 1)'(1);
  localparam logic [pend_bits-1:0] PtrOne    = pend_bits'(1);

  // State
  logic [NPorts-1:0]    r_issued;
  logic                 r_grant_valid;
  logic [port_bits-1:0] r_grant_idx;
  logic [port_bits-1:0] r_queue [Depth];
  logic [pend_bits-1:0] r_rd_ptr;
  logic [pend_bits-1:0] r_wr_ptr;
  logic [pend_bits:0]   r_pending;
`ifndef HPDMC_BUSIF_FIXED_PRIO_EN
  logic [port_bits-1:0] r_last_grant;
  logic [port_bits-1:0] w_last_grant_nxt;
  logic [port_bits-1:0] w_cand;
`endif

  // Next-state
  logic [NPorts-1:0]    w_issued_nxt;
  logic                 w_grant_valid_nxt;
  logic [port_bits-1:0] w_grant_idx_nxt;
  logic [pend_bits-1:0] w_rd_ptr_nxt;
  logic [pend_bits-1:0] w_wr_ptr_nxt;
  logic [pend_bits:0]   w_pending_nxt;

  // Combinational helpers
  logic [NPorts-1:0]    w_elig;
  logic                 w_found;
  logic [port_bits-1:0] w_win;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [NPorts-1:0]    w_head_oh;
  logic [NPorts-1:0]    w_grant_oh;
  logic                 w_unused_adr_lsbs;

  // A port already holding a queue entry must not raise a second command.
  assign w_elig = fml_stb & ~r_issued;

  // Winner search; iterating from the far end lets the nearest candidate win.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
`ifdef HPDMC_BUSIF_FIXED_PRIO_EN
    for (int i = NPorts - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_found = 1'b1;
        w_win   = port_bits'(i);
      end
    end
`else
    w_cand = '0;
    // Offset NPorts wraps back to last_grant itself, so it is checked last.
    for (int i = NPorts; i >= 1; i--) begin
      w_cand = r_last_grant + port_bits'(i);
      if (w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
`endif
  end

  assign w_full   = (r_pending == FullCount);
  assign mgmt_stb = r_grant_valid & ~w_full;
  assign mgmt_we  = fml_we[r_grant_idx];
  assign mgmt_address = fml_adr[r_grant_idx * sdram_depth + 3 +: sdram_depth - 3];

  assign w_push = mgmt_ack & mgmt_stb;
  assign w_pop  = data_ack & (r_pending != '0);

  assign data_port = r_queue[r_rd_ptr];
  assign pending   = r_pending;

  always_comb begin
    w_head_oh = '0;
    w_head_oh[data_port] = 1'b1;
    w_grant_oh = '0;
    w_grant_oh[r_grant_idx] = 1'b1;
  end

  assign fml_ack = w_pop ? w_head_oh : '0;

  // Byte-within-word address bits are not used by mgmt.
  always_comb begin
    w_unused_adr_lsbs = 1'b0;
    for (int p = 0; p < NPorts; p++) begin
      w_unused_adr_lsbs = w_unused_adr_lsbs ^ (^fml_adr[p * sdram_depth +: 3]);
    end
  end

  // Next-state logic
  always_comb begin
    w_grant_valid_nxt = r_grant_valid;
    w_grant_idx_nxt   = r_grant_idx;
`ifndef HPDMC_BUSIF_FIXED_PRIO_EN
    w_last_grant_nxt  = r_last_grant;
`endif
    w_rd_ptr_nxt      = r_rd_ptr;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_pending_nxt     = r_pending;

    if (w_push) begin
      w_grant_valid_nxt = 1'b0;
`ifndef HPDMC_BUSIF_FIXED_PRIO_EN
      w_last_grant_nxt  = r_grant_idx;
`endif
    end else if (!r_grant_valid && w_found) begin
      w_grant_valid_nxt = 1'b1;
      w_grant_idx_nxt   = w_win;
    end

    // The pushed port is never the popped one: a queued port cannot be granted.
    w_issued_nxt = (r_issued | (w_push ? w_grant_oh : '0)) & ~fml_ack;

    if (w_push) w_wr_ptr_nxt = r_wr_ptr + PtrOne;
    if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PtrOne;

    unique case ({w_push, w_pop})
      2'b10:   w_pending_nxt = r_pending + PendOne;
      2'b01:   w_pending_nxt = r_pending - PendOne;
      default: w_pending_nxt = r_pending;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sdram_rst) begin
      r_issued      <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
`ifndef HPDMC_BUSIF_FIXED_PRIO_EN
      r_last_grant  <= port_bits'(NPorts - 1);
`endif
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_pending     <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_queue[i] <= '0;
      end
    end else begin
      r_issued      <= w_issued_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
`ifndef HPDMC_BUSIF_FIXED_PRIO_EN
      r_last_grant  <= w_last_grant_nxt;
`endif
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_pending     <= w_pending_nxt;
      if (w_push) begin
        r_queue[r_wr_ptr] <= r_grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_hpdmc_busif_mp.sv
// Directed bench for hpdmc_busif_mp: a default 2-port/4-deep instance and a
// 4-port/2-deep instance for the queue-full case.
module tb_hpdmc_busif_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance: 2 ports, depth 4
  logic [51:0] adr;
  logic [1:0]  stb, we, fack;
  logic        mstb, mwe, mack, dack;
  logic [22:0] maddr;
  logic [0:0]  dport;
  logic [2:0]  pend;

  // Small instance: 4 ports, depth 2
  logic [103:0] adr2;
  logic [3:0]   stb2, we2, fack2;
  logic         mstb2, mwe2, mack2, dack2;
  logic [22:0]  maddr2;
  logic [1:0]   dport2;
  logic [1:0]   pend2;

  hpdmc_busif_mp #(.sdram_depth(26), .port_bits(1), .pend_bits(2)) dut (
    .sys_clk(clk), .sdram_rst(rst), .fml_adr(adr), .fml_stb(stb), .fml_we(we),
    .fml_ack(fack), .mgmt_stb(mstb), .mgmt_we(mwe), .mgmt_address(maddr),
    .mgmt_ack(mack), .data_ack(dack), .data_port(dport), .pending(pend)
  );

  hpdmc_busif_mp #(.sdram_depth(26), .port_bits(2), .pend_bits(1)) dut2 (
    .sys_clk(clk), .sdram_rst(rst), .fml_adr(adr2), .fml_stb(stb2), .fml_we(we2),
    .fml_ack(fack2), .mgmt_stb(mstb2), .mgmt_we(mwe2), .mgmt_address(maddr2),
    .mgmt_ack(mack2), .data_ack(dack2), .data_port(dport2), .pending(pend2)
  );

  int total = 0;
  int bad   = 0;
  int unsigned g [5];
  logic [31:0] exp_addr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = '0; mack = 0; dack = 0;
    stb2 = '0; mack2 = 0; dack2 = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
`ifdef HPDMC_BUSIF_FIXED_PRIO_EN
    g = '{0, 0, 1, 0, 1};
`else
    g = '{0, 1, 0, 1, 0};
`endif
    exp_addr[0] = 32'h8;
    exp_addr[1] = 32'h20;
    adr  = {26'h100, 26'h40};
    we   = 2'b00;
    adr2 = {26'h20, 26'h18, 26'h10, 26'h08};
    we2  = 4'b0000;

    // Reset values
    do_reset();
    #2;
    chk("rst_fml_ack", fack, 0);
    chk("rst_mgmt_stb", mstb, 0);
    chk("rst_data_port", dport, 0);
    chk("rst_pending", pend, 0);
    chk("rst_pending2", pend2, 0);

    // Queue full on the 4-port/2-deep instance
    cyc();
    stb2 = 4'b1111;
    #2 chk("qf_arb_stb", mstb2, 0);
    cyc();
    chk("qf_c0_stb", mstb2, 1);
    chk("qf_c0_addr", maddr2, 1);
    mack2 = 1;
    cyc();
    mack2 = 0;
    #2 chk("qf_p1", pend2, 1);
    chk("qf_bubble_stb", mstb2, 0);
    cyc();
    chk("qf_c1_stb", mstb2, 1);
    chk("qf_c1_addr", maddr2, 2);
    mack2 = 1;
    cyc();
    mack2 = 0;
    #2 chk("qf_p2", pend2, 2);
    cyc();
    #2 chk("qf_full_stb", mstb2, 0);
    chk("qf_full_pend", pend2, 2);
    chk("qf_head", dport2, 0);
    cyc();
    dack2 = 1;
    #2 chk("qf_fack", fack2, 4'b0001);
    chk("qf_full_stb2", mstb2, 0);
    cyc();
    dack2 = 0;
    #2 chk("qf_resume_stb", mstb2, 1);
    chk("qf_resume_addr", maddr2, 3);
    chk("qf_resume_pend", pend2, 1);
    chk("qf_resume_head", dport2, 1);

    // Single command, port 0
    do_reset();
    stb = 2'b01;
    #2 chk("t1_arb_stb", mstb, 0);
    cyc();
    chk("t1_stb", mstb, 1);
    chk("t1_addr", maddr, 32'h8);
    chk("t1_we", mwe, 0);
    mack = 1;
    cyc();
    mack = 0;
    #2 chk("t1_pend", pend, 1);
    chk("t1_stb_low", mstb, 0);
    cyc();
    #2 chk("t1_no_reissue", mstb, 0);
    dack = 1;
    #1 chk("t1_fack", fack, 2'b01);
    cyc();
    dack = 0;
    stb = 2'b00;
    #2 chk("t1_pend0", pend, 0);
    chk("t1_fack0", fack, 0);

    // Both ports together, no data_ack
    do_reset();
    we  = 2'b10;
    stb = 2'b11;
    #2 chk("t2_arb_stb", mstb, 0);
    cyc();
    chk("t2_c0_stb", mstb, 1);
    chk("t2_c0_addr", maddr, 32'h8);
    chk("t2_c0_we", mwe, 0);
    mack = 1;
    cyc();
    mack = 0;
    #2 chk("t2_p1", pend, 1);
    chk("t2_bubble", mstb, 0);
    cyc();
    #2 chk("t2_c1_stb", mstb, 1);
    chk("t2_c1_addr", maddr, 32'h20);
    chk("t2_c1_we", mwe, 1);
    mack = 1;
    cyc();
    mack = 0;
    #2 chk("t2_p2", pend, 2);
    chk("t2_head", dport, 0);
    chk("t2_stb_low", mstb, 0);
    cyc();
    #2 chk("t2_no_reissue_a", mstb, 0);
    cyc();
    #2 chk("t2_no_reissue_b", mstb, 0);

    // Reset with two commands pending
    rst = 1;
    stb = 2'b00;
    cyc();
    rst = 0;
    #2 chk("rs_pend", pend, 0);
    chk("rs_stb", mstb, 0);
    chk("rs_fack", fack, 0);
    dack = 1;
    #1 chk("rs_stray_fack", fack, 0);
    cyc();
    dack = 0;
    #2 chk("rs_stray_pend", pend, 0);

    // Arbitration fairness, then simultaneous push and pop
    do_reset();
    we  = 2'b00;
    stb = 2'b01;
    #2 chk("f_arb", mstb, 0);
    cyc();
    chk("f_g0_stb", mstb, 1);
    chk("f_g0_addr", maddr, exp_addr[g[0]]);
    mack = 1;
    cyc();
    mack = 0;
    dack = 1;
    #2 chk("f_ack0", fack, 32'(1) << g[0]);
    cyc();
    dack = 0;
    stb  = 2'b11;
    #2 chk("f_p0", pend, 0);
    chk("f_arb1", mstb, 0);
    cyc();
    #2 chk("f_g1_stb", mstb, 1);
    chk("f_g1_addr", maddr, exp_addr[g[1]]);
    mack = 1;
    cyc();
    mack = 0;
    dack = 1;
    #2 chk("f_ack1", fack, 32'(1) << g[1]);
    chk("f_bubble", mstb, 0);
    cyc();
    dack = 0;
    #2 chk("f_g2_stb", mstb, 1);
    chk("f_g2_addr", maddr, exp_addr[g[2]]);
    mack = 1;
    cyc();
    mack = 0;
    dack = 1;
    #2 chk("f_ack2", fack, 32'(1) << g[2]);
    cyc();
    dack = 0;
    #2 chk("f_g3_stb", mstb, 1);
    chk("f_g3_addr", maddr, exp_addr[g[3]]);
    mack = 1;
    cyc();
    mack = 0;
    #2 chk("f_p1", pend, 1);
    chk("f_head3", dport, g[3]);
    chk("f_stb_low", mstb, 0);
    cyc();
    #2 chk("f_g4_stb", mstb, 1);
    chk("f_g4_addr", maddr, exp_addr[g[4]]);
    mack = 1;
    dack = 1;
    #1 chk("sc_fack_old_head", fack, 32'(1) << g[3]);
    cyc();
    mack = 0;
    dack = 0;
    #2 chk("sc_pend", pend, 1);
    chk("sc_head_new", dport, g[4]);
    stb  = 2'b00;
    dack = 1;
    cyc();
    dack = 0;
    #2 chk("sc_drain", pend, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
